// File: rtl/clip_player_pkg.sv
// Shared types and helpers for the multi-voice clip player / mixer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, accumulator/address width functions and a
// generic two's-complement clamp used on the mixed output.
package clip_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Mix accumulator width. The +1 and the log2 term together leave headroom
  // for NUM_VOICES full-scale terms, so the running sum never wraps.
  function automatic int acc_width(input int sample_bits, input int num_voices);
    return sample_bits + $clog2(num_voices) + 1;
  endfunction

  // Clip memory address width: every voice owns CLIP_LEN consecutive words.
  function automatic int addr_width(input int num_voices, input int clip_len);
    return $clog2(num_voices * clip_len);
  endfunction

  // Clamp a signed value into the range of a 'bits'-wide signed word.
  // The result is kept 64 bits wide; callers size-cast it to their width.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/clip_voice_ctrl.sv
// Per-voice playback state: position, active flag and pending trigger.
// Latency: state changes only on the cycle 'advance' is high; trigger latched any cycle.
// Backpressure: none; repeated triggers before an advance collapse into one.
//
// Ports:
//   mclk, rst          clock, synchronous active-high reset
//   advance            one-cycle frame-end strobe from the mixer FSM
//   trigger            one-cycle start/restart request
//   loop_en            loop mode, looked at only when the clip end is reached
//   pos                current sample position within the clip
//   active             voice is playing (contributes to the mix)
module clip_voice_ctrl #(
  parameter int CLIP_LEN = 32
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic                        advance,
  input  logic                        trigger,
  input  logic                        loop_en,
  output logic [$clog2(CLIP_LEN)-1:0] pos,
  output logic                        active
);

  localparam int PW = $clog2(CLIP_LEN);

  logic [PW-1:0] pos_q, pos_d;
  logic          active_q, active_d;
  logic          pending_q, pending_d;

  always_comb begin
    pos_d     = pos_q;
    active_d  = active_q;
    pending_d = pending_q | trigger;
    if (advance) begin
      // The advance consumes the trigger latched so far; a trigger in this
      // very cycle survives as pending for the following advance.
      pending_d = trigger;
      if (pending_q) begin
        pos_d    = '0;
        active_d = 1'b1;
      end else if (active_q && (pos_q == PW'(CLIP_LEN - 1))) begin
        pos_d    = '0;
        active_d = loop_en;
      end else if (active_q) begin
        pos_d = pos_q + PW'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      pos_q     <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign pos    = pos_q;
  assign active = active_q;

endmodule

// File: rtl/clip_player_mixer.sv
// Multi-voice triggered clip player: reads one word per voice, scales and mixes.
// Latency: valid pulses NUM_VOICES+3 cycles after m_sample_index==0 is seen in IDLE.
// Backpressure: none; consumer must accept the one-cycle valid pulse.
//
// Ports:
//   mclk, rst          master clock (256x sample rate), synchronous active-high reset
//   m_sample_index     consumer position in the sample period; 0 starts a frame
//   trigger, loop_en   per-voice start request and loop mode
//   volume             per-voice unsigned gain, VOLUME_BITS each, voice v at [v*VOLUME_BITS +: VOLUME_BITS]
//   mem_addr/mem_rdata clip memory read port, data one cycle after address
//   p_sample_buffer    mixed signed sample, held between valid pulses
//   valid              one-cycle update strobe
//   busy               per-voice active flags
// Build option: define CLIP_PLAYER_SAT_EN to clamp the mix instead of wrapping it.
module clip_player_mixer
  import clip_player_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int CLIP_LEN    = 32,
  parameter int NUM_VOICES  = 4,
  parameter int VOLUME_BITS = 4
) (
  input  logic                                                    mclk,
  input  logic                                                    rst,
  input  logic [7:0]                                              m_sample_index,
  input  logic [NUM_VOICES-1:0]                                   trigger,
  input  logic [NUM_VOICES-1:0]                                   loop_en,
  input  logic [NUM_VOICES*VOLUME_BITS-1:0]                       volume,
  output logic [clip_player_pkg::addr_width(NUM_VOICES, CLIP_LEN)-1:0] mem_addr,
  input  logic signed [SAMPLE_BITS-1:0]                           mem_rdata,
  output logic signed [SAMPLE_BITS-1:0]                           p_sample_buffer,
  output logic                                                    valid,
  output logic [NUM_VOICES-1:0]                                   busy
);

  localparam int AW    = addr_width(NUM_VOICES, CLIP_LEN);
  localparam int ACCW  = acc_width(SAMPLE_BITS, NUM_VOICES);
  localparam int PW    = $clog2(CLIP_LEN);
  localparam int VCW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PRODW = SAMPLE_BITS + VOLUME_BITS + 1;

  state_e                  state_q, state_d;
  logic [VCW-1:0]          vcnt_q, vcnt_d;
  logic                    rd_en_q, rd_en_d;
  logic [VCW-1:0]          rd_voice_q, rd_voice_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic signed [SAMPLE_BITS-1:0] out_q, out_d;
  logic                    valid_q, valid_d;

  logic [PW-1:0]           pos_w [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_w;
  logic                    advance;

  logic [VCW-1:0]          addr_voice;
  logic [AW-1:0]           addr_sel;
  logic [VOLUME_BITS-1:0]  vol_sel;
  logic                    act_sel;
  logic signed [VOLUME_BITS:0]   vol_s;
  logic signed [PRODW-1:0]       prod;
  logic signed [SAMPLE_BITS:0]   term;

  assign advance = (state_q == OUT);

  genvar g;
  for (g = 0; g < NUM_VOICES; g++) begin : g_voice
    clip_voice_ctrl #(.CLIP_LEN(CLIP_LEN)) u_voice (
      .mclk    (mclk),
      .rst     (rst),
      .advance (advance),
      .trigger (trigger[g]),
      .loop_en (loop_en[g]),
      .pos     (pos_w[g]),
      .active  (active_w[g])
    );
  end

  // Address for the voice read next cycle: voice 0 when leaving IDLE,
  // otherwise the one after the voice currently on the bus.
  always_comb begin
    addr_voice = (state_q == IDLE) ? '0 : (vcnt_q + VCW'(1));
    addr_sel   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (addr_voice == VCW'(v)) begin
        addr_sel = AW'(v * CLIP_LEN) + AW'(pos_w[v]);
      end
    end
  end

  // MAC operand select for the voice whose data is on mem_rdata this cycle.
  always_comb begin
    vol_sel = '0;
    act_sel = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rd_voice_q == VCW'(v)) begin
        vol_sel = volume[v*VOLUME_BITS +: VOLUME_BITS];
        act_sel = active_w[v];
      end
    end
    vol_s = {1'b0, vol_sel};
    prod  = PRODW'(mem_rdata) * PRODW'(vol_s);
    // Arithmetic shift floors toward -inf; the scaled term always fits in
    // SAMPLE_BITS+1 bits because the gain is strictly below 1.0.
    term  = (SAMPLE_BITS + 1)'(prod >>> VOLUME_BITS);
  end

  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    rd_en_d    = 1'b0;
    rd_voice_d = vcnt_q;
    acc_d      = acc_q;
    mem_addr_d = mem_addr_q;
    out_d      = out_q;
    valid_d    = 1'b0;

    if (rd_en_q && act_sel) begin
      acc_d = acc_q + ACCW'(term);
    end

    case (state_q)
      IDLE: begin
        if (m_sample_index == 8'd0) begin
          state_d    = READ;
          vcnt_d     = '0;
          acc_d      = '0;
          mem_addr_d = addr_sel;
        end
      end
      READ: begin
        // The address for vcnt_q is on the bus now; its data lands next cycle.
        rd_en_d    = 1'b1;
        rd_voice_d = vcnt_q;
        if (vcnt_q == VCW'(NUM_VOICES - 1)) begin
          state_d = DRAIN;
        end else begin
          vcnt_d     = vcnt_q + VCW'(1);
          mem_addr_d = addr_sel;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
`ifdef CLIP_PLAYER_SAT_EN
        out_d = SAMPLE_BITS'(sat_clamp(64'(acc_q), SAMPLE_BITS));
`else
        out_d = SAMPLE_BITS'(acc_q);
`endif
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= IDLE;
      vcnt_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_voice_q <= '0;
      acc_q      <= '0;
      mem_addr_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      rd_en_q    <= rd_en_d;
      rd_voice_q <= rd_voice_d;
      acc_q      <= acc_d;
      mem_addr_q <= mem_addr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_addr        = mem_addr_q;
  assign p_sample_buffer = out_q;
  assign valid           = valid_q;
  assign busy            = active_w;

endmodule

// File: tb/tb_clip_player_mixer.sv
// Self-checking bench for clip_player_mixer (2 voices, 4-sample clips, 4-bit volume).
// Frames are driven 8 cycles apart; a behavioural model tracks voice state and mix.
// Honours CLIP_PLAYER_SAT_EN for the expected saturation behaviour.
module tb_clip_player_mixer;

  localparam int SB = 16;
  localparam int CL = 4;
  localparam int NV = 2;
  localparam int VB = 4;

  logic               mclk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         m_sample_index = 8'd1;
  logic [NV-1:0]      trigger = '0;
  logic [NV-1:0]      loop_en = '0;
  logic [NV*VB-1:0]   volume = '0;
  logic [2:0]         mem_addr;
  logic signed [SB-1:0] mem_rdata;
  logic signed [SB-1:0] p_sample_buffer;
  logic               valid;
  logic [NV-1:0]      busy;

  int checks = 0;
  int errors = 0;

  // Reference state
  int mem_m [NV*CL];
  int vol_m [NV];
  int m_pos [NV];
  bit m_act [NV];
  bit m_pend [NV];
  int m_out;
  int s [10];

  clip_player_mixer #(
    .SAMPLE_BITS(SB), .CLIP_LEN(CL), .NUM_VOICES(NV), .VOLUME_BITS(VB)
  ) dut (
    .mclk            (mclk),
    .rst             (rst),
    .m_sample_index  (m_sample_index),
    .trigger         (trigger),
    .loop_en         (loop_en),
    .volume          (volume),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .p_sample_buffer (p_sample_buffer),
    .valid           (valid),
    .busy            (busy)
  );

  always #5 mclk = ~mclk;

  // Synchronous-read clip memory.
  always @(posedge mclk) mem_rdata <= 16'(mem_m[mem_addr]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_volume();
    volume = {4'(vol_m[1]), 4'(vol_m[0])};
  endtask

  function automatic int floor_scale(input int p);
    int d = 1 << VB;
    return (p >= 0) ? (p / d) : -((-p + d - 1) / d);
  endfunction

  function automatic int model_mix();
    int sum = 0;
    int maxv = (1 << (SB - 1)) - 1;
    for (int v = 0; v < NV; v++)
      if (m_act[v]) sum += floor_scale(mem_m[v*CL + m_pos[v]] * vol_m[v]);
`ifdef CLIP_PLAYER_SAT_EN
    if (sum > maxv) sum = maxv;
    if (sum < -maxv - 1) sum = -maxv - 1;
`else
    sum = sum & ((1 << SB) - 1);
    if (sum > maxv) sum -= (1 << SB);
`endif
    return sum;
  endfunction

  task automatic model_advance(input logic [NV-1:0] lp);
    for (int v = 0; v < NV; v++) begin
      if (m_pend[v]) begin
        m_pos[v] = 0; m_act[v] = 1; m_pend[v] = 0;
      end else if (m_act[v] && m_pos[v] == CL - 1) begin
        m_pos[v] = 0; m_act[v] = lp[v];
      end else if (m_act[v]) begin
        m_pos[v] = m_pos[v] + 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_pos[v] = 0; m_act[v] = 0; m_pend[v] = 0;
    end
    m_out = 0;
  endtask

  // One 8-cycle frame: k=0 presents m_sample_index==0, OUT is cycle k=4,
  // valid is expected in k=5. tk = trigger cycle, rk = reset cycle,
  // sk = extra m_sample_index==0 inside the frame (-1 = none).
  task automatic run_frame(input logic [NV-1:0] tmask, input int tk, input logic [NV-1:0] lp,
                           input int rk, input int sk, output int seen);
    int a0, a1;
    bit aborted;
    aborted = 0;
    a0 = m_pos[0];
    a1 = CL + m_pos[1];
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge mclk);
      if (k == 1 && !aborted) chk("addr_v0", 32'(mem_addr), 32'(a0));
      if (k == 2 && !aborted) chk("addr_v1", 32'(mem_addr), 32'(a1));
      if (aborted) chk("addr_after_rst", 32'(mem_addr), 32'd0);
      chk("valid", 32'(valid), 32'((k == 5) && !aborted));
      chk("sample", 32'(p_sample_buffer), 32'(m_out));
      chk("busy", 32'(busy), 32'({m_act[1], m_act[0]}));
      if (k == 6) seen = int'(p_sample_buffer);
      m_sample_index = (k == 0 || k == sk) ? 8'd0 : 8'(k);
      trigger = (k == tk) ? tmask : '0;
      loop_en = lp;
      rst     = (k == rk);
      if (k == rk) begin
        model_clear();
        aborted = 1;
      end else begin
        if (k == 4 && !aborted) begin
          m_out = model_mix();
          model_advance(lp);
        end
        if (k == tk)
          for (int v = 0; v < NV; v++) if (tmask[v]) m_pend[v] = 1;
      end
    end
  endtask

  initial begin
    int sat_exp;
    mem_m = '{1000, 2000, -3000, 4000, 16000, 16000, 16000, 16000};
    vol_m = '{15, 15};
    set_volume();
    model_clear();

    // Reset state
    repeat (3) @(negedge mclk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sample", 32'(p_sample_buffer), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    // Single shot on voice 0; a stray index==0 mid-frame must be ignored
    for (int f = 0; f < 6; f++)
      run_frame((f == 0) ? 2'b01 : 2'b00, 1, 2'b00, -1, (f == 2) ? 2 : -1, s[f]);
    chk("ss_first", 32'(s[0]), 32'd0);
    chk("ss_s0", 32'(s[1]), 32'(937));
    chk("ss_s1", 32'(s[2]), 32'(1875));
    chk("ss_s2", 32'(s[3]), 32'(-2813));
    chk("ss_s3", 32'(s[4]), 32'(3750));
    chk("ss_after", 32'(s[5]), 32'd0);
    chk("ss_busy_end", 32'(busy), 32'd0);

    // Loop mode on voice 0
    for (int f = 0; f < 7; f++)
      run_frame((f == 0) ? 2'b01 : 2'b00, 0, 2'b01, -1, -1, s[f]);
    chk("loop_wrap0", 32'(s[5]), 32'(937));
    chk("loop_wrap1", 32'(s[6]), 32'(1875));
    chk("loop_busy", 32'(busy[0]), 32'd1);

    // Reset two cycles into a frame with voice 0 looping
    run_frame(2'b00, -1, 2'b01, 2, -1, s[0]);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sample", 32'(p_sample_buffer), 32'd0);
    run_frame(2'b00, -1, 2'b01, -1, -1, s[1]);
    chk("midrst_idle", 32'(s[1]), 32'd0);

    // Retrigger during the OUT cycle of the second frame
    run_frame(2'b01, 2, 2'b00, -1, -1, s[0]);
    run_frame(2'b01, 4, 2'b00, -1, -1, s[1]);
    run_frame(2'b00, -1, 2'b00, -1, -1, s[2]);
    run_frame(2'b00, -1, 2'b00, -1, -1, s[3]);
    chk("retrig_a", 32'(s[1]), 32'(937));
    chk("retrig_b", 32'(s[2]), 32'(1875));
    chk("retrig_c", 32'(s[3]), 32'(937));

    // Saturation / wrap with both voices at full scale
    run_frame(2'b00, -1, 2'b00, 3, -1, s[0]);
    for (int i = 0; i < NV*CL; i++) mem_m[i] = 32767;
`ifdef CLIP_PLAYER_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -4098;
`endif
    run_frame(2'b11, 0, 2'b11, -1, -1, s[0]);
    run_frame(2'b00, -1, 2'b11, -1, -1, s[1]);
    chk("sat_mix", 32'(s[1]), 32'(sat_exp));

    // Randomized frames against the model
    for (int f = 0; f < 24; f++) begin
      int rk;
      for (int i = 0; i < NV*CL; i++) mem_m[i] = int'($urandom_range(65535)) - 32768;
      vol_m[0] = int'($urandom_range(15));
      vol_m[1] = int'($urandom_range(15));
      set_volume();
      rk = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : -1;
      run_frame(2'($urandom_range(3)), int'($urandom_range(7)), 2'($urandom_range(3)),
                rk, int'($urandom_range(4)), s[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clip_player_mixer.md
# clip_player_mixer

Multi-voice, triggered clip player and mixer. Successor to the single-voice stub player in the audio-consumer domain. Runs on `mclk` and produces one mixed signed sample per 256-cycle sample period, aligned to `m_sample_index`. Each voice owns a fixed region of a shared external clip memory, plays once or loops, and is scaled by its own volume before saturating summation into the I2S/DAC consumer path.

## Interface
Parameters:
- `SAMPLE_BITS`, 16: signed sample width (memory data and output).
- `CLIP_LEN`, 32: samples per voice clip; power of two, ≥2.
- `NUM_VOICES`, 4: voice count, 1..64.
- `VOLUME_BITS`, 4: unsigned per-voice volume width.

Ports (clock and reset first):
- `mclk`  in  1: master clock, 256× sample rate.
- `rst`  in  1: synchronous, active-high reset.
- `m_sample_index`  in  8: consumer's position in the sample period, 0..255.
- `trigger`  in  NUM_VOICES: one-cycle start/restart request per voice.
- `loop_en`  in  NUM_VOICES: per-voice loop mode, sampled at clip end.
- `volume`  in  NUM_VOICES*VOLUME_BITS: voice v occupies bits `[v*VOLUME_BITS +: VOLUME_BITS]`.
- `mem_addr`  out  $clog2(NUM_VOICES*CLIP_LEN): registered clip-memory read address.
- `mem_rdata`  in  SAMPLE_BITS: memory data, valid exactly 1 cycle after `mem_addr`.
- `p_sample_buffer`  out  SAMPLE_BITS: mixed signed output sample.
- `valid`  out  1: one-cycle pulse when `p_sample_buffer` updates.
- `busy`  out  NUM_VOICES: voice active flags.

## Operation
- Memory map: voice v reads `v*CLIP_LEN + pos[v]`.
- Per-voice state: `pos` (0..CLIP_LEN-1), `active`, `pending`.
- A `trigger[v]` pulse in any cycle sets `pending[v]`. Repeated pulses before the next advance collapse into one.
- FSM: IDLE → READ → DRAIN → OUT → IDLE.
  - IDLE: leave when `m_sample_index==0`. Clear the accumulator and load voice counter 0.
  - READ: one voice per cycle; drive `mem_addr` for voice v; go to DRAIN after voice NUM_VOICES-1.
  - DRAIN: one cycle; accumulate the last voice.
  - OUT: saturate, register the output, pulse `valid`, advance voices.
- `m_sample_index==0` outside IDLE is ignored.
- Accumulate: `(mem_rdata signed × volume unsigned) >>> VOLUME_BITS`, arithmetic, floor.
  - Inactive voices add 0.
  - Accumulator width: SAMPLE_BITS + $clog2(NUM_VOICES) + 1, so it never overflows internally.
- Voice advance at OUT, in priority order:
  - `pending`: pos←0, active←1, pending←0. Sample 0 plays in the next frame.
  - `active` and pos==CLIP_LEN-1: pos←0; active←`loop_en[v]`.
  - `active`: pos←pos+1.
  - Otherwise: hold.
- A trigger arriving in the OUT cycle itself is kept pending for the next advance.
- `busy = active`.

## Timing
- t0 = the cycle `m_sample_index==0` is sampled in IDLE.
- `mem_addr` for voice v is valid in cycle t0+1+v.
- Data for voice v is accumulated at the end of cycle t0+2+v.
- `valid` is high in cycle t0+NUM_VOICES+3 for exactly one cycle; `p_sample_buffer` and `busy` update on the same edge.
- `p_sample_buffer` holds its value until the next `valid`.
- Frame length is NUM_VOICES+3 cycles, at most 67, which is less than 256.
- Reset values: `p_sample_buffer`=0, `valid`=0, `busy`=0, `mem_addr`=0, FSM=IDLE, all pos/active/pending=0.
- `rst` mid-frame aborts the frame: no `valid` is emitted and triggers not yet applied are lost.

## Configuration
- `CLIP_PLAYER_SAT_EN` defined: the output clamps to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
- Undefined: the output is the low SAMPLE_BITS of the accumulator (two's-complement wrap).

## Structure
- Package `clip_player_pkg`:
  - FSM state enum (IDLE, READ, DRAIN, OUT).
  - Accumulator-width and address-width constant functions.
  - Saturation function.
- Sub-module `clip_voice_ctrl`: one instance per voice via generate. Holds pos/active/pending and implements the advance rules; ports `advance`, `trigger`, `loop_en`, `pos`, `active`.
- The top level holds the FSM, address mux, MAC and output register.

## Test plan
Common setup: NUM_VOICES=2, CLIP_LEN=4, VOLUME_BITS=4. Voice 0 memory = {1000, 2000, -3000, 4000}; voice 1 memory = all 16000.
- **Single shot:** trigger[0] with volume0=15, voice 1 idle → successive valid outputs 937, 1875, -2813, 3750. busy[0] falls on the 4th `valid` edge; later outputs are 0.
- **Loop:** loop_en[0]=1 → the output sequence repeats with period 4 and busy[0] stays 1.
- **Saturation:** both voices hold 32767, volume 15, both triggered → `p_sample_buffer`=32767 with the macro defined, -4098 without.
- **Retrigger:** trigger[0] during the OUT cycle of the 2nd sample → next sample is 1875, then restart at 937.
- **Timing:** `m_sample_index` goes 0 at cycle t0 → `mem_addr` = 0 then 4 in cycles t0+1 and t0+2; `valid` in t0+5 only.
- **Reset:** `rst` asserted at t0+2 → no `valid` that frame; all outputs 0; voices idle until triggered again.
